// File: rtl/up_control_unit_pkg.sv
// Shared opcodes, ALU select codes, FSM states and the strobe bundle
// for the 4-bit uP control unit.
package up_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ADDR,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_CMPI  = 4'h4;
  localparam logic [3:0] OP_NANDI = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_OUT   = 4'h7;
  localparam logic [3:0] OP_LD    = 4'h8;
  localparam logic [3:0] OP_ST    = 4'h9;
  localparam logic [3:0] OP_ADDM  = 4'hA;
  localparam logic [3:0] OP_SUBM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_JC    = 4'hD;
  localparam logic [3:0] OP_JZ    = 4'hE;
  localparam logic [3:0] OP_HLT   = 4'hF;

  localparam logic [2:0] SEL_A    = 3'b000;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_NAND = 3'b100;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_ADD  = 3'b011;

  typedef struct packed {
    logic       pc_en;
    logic       pc_ld;
    logic       fetch_en;
    logic       addr_ld;
    logic       acc_en;
    logic [2:0] alu_sel;
    logic       oprnd_oe;
    logic       in_oe;
    logic       acc_oe;
    logic       ram_cs;
    logic       ram_we;
    logic       out_en;
    logic       halted;
  } ctrl_t;

  function automatic logic two_byte(input logic [3:0] op);
    return (op >= OP_LD) && (op <= OP_JZ);
  endfunction

  function automatic logic sets_flags(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) ||
           (op == OP_CMPI) || (op == OP_ADDM) ||
           (op == OP_SUBM);
  endfunction

endpackage

// File: rtl/up_ctrl_decode.sv
// Combinational strobe decode from FSM state, opcode and
// registered flags.
module up_ctrl_decode
  import up_control_unit_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] instr_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        ctrl_o.fetch_en = 1'b1;
        ctrl_o.pc_en    = 1'b1;
      end
      ST_ADDR: begin
        ctrl_o.addr_ld = 1'b1;
        ctrl_o.pc_en   = 1'b1;
      end
      ST_EXEC: begin
        unique case (instr_i)
          OP_LIT: begin
            ctrl_o.oprnd_oe = 1'b1;
            ctrl_o.alu_sel  = SEL_B;
            ctrl_o.acc_en   = 1'b1;
          end
          OP_ADDI: begin
            ctrl_o.oprnd_oe = 1'b1;
            ctrl_o.alu_sel  = SEL_ADD;
            ctrl_o.acc_en   = 1'b1;
          end
          OP_SUBI: begin
            ctrl_o.oprnd_oe = 1'b1;
            ctrl_o.alu_sel  = SEL_SUB;
            ctrl_o.acc_en   = 1'b1;
          end
          OP_CMPI: begin
            ctrl_o.oprnd_oe = 1'b1;
            ctrl_o.alu_sel  = SEL_SUB;
          end
          OP_NANDI: begin
            ctrl_o.oprnd_oe = 1'b1;
            ctrl_o.alu_sel  = SEL_NAND;
            ctrl_o.acc_en   = 1'b1;
          end
          OP_IN: begin
            ctrl_o.in_oe   = 1'b1;
            ctrl_o.alu_sel = SEL_B;
            ctrl_o.acc_en  = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.acc_oe = 1'b1;
            ctrl_o.out_en = 1'b1;
          end
          OP_LD: begin
            ctrl_o.ram_cs  = 1'b1;
            ctrl_o.alu_sel = SEL_B;
            ctrl_o.acc_en  = 1'b1;
          end
          OP_ST: begin
            ctrl_o.acc_oe = 1'b1;
            ctrl_o.ram_cs = 1'b1;
            ctrl_o.ram_we = 1'b1;
          end
          OP_ADDM: begin
            ctrl_o.ram_cs  = 1'b1;
            ctrl_o.alu_sel = SEL_ADD;
            ctrl_o.acc_en  = 1'b1;
          end
          OP_SUBM: begin
            ctrl_o.ram_cs  = 1'b1;
            ctrl_o.alu_sel = SEL_SUB;
            ctrl_o.acc_en  = 1'b1;
          end
          OP_JMP: ctrl_o.pc_ld = 1'b1;
          OP_JC:  ctrl_o.pc_ld = flag_c_i;
          OP_JZ:  ctrl_o.pc_ld = flag_z_i;
          default: ;
        endcase
      end
      ST_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/up_control_unit.sv
// Instruction sequencer for the 4-bit uP: FSM, C/Z flag register
// and strobe decode for every datapath enable.
module up_control_unit
  import up_control_unit_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic [3:0] INSTR,
  input  logic       ALU_C,
  input  logic       ALU_Z,
  output logic       PC_EN,
  output logic       PC_LD,
  output logic       FETCH_EN,
  output logic       ADDR_LD,
  output logic       ACC_EN,
  output logic [2:0] ALU_SEL,
  output logic       OPRND_OE,
  output logic       IN_OE,
  output logic       ACC_OE,
  output logic       RAM_CS,
  output logic       RAM_WE,
  output logic       OUT_EN,
  output logic       FLAG_C,
  output logic       FLAG_Z,
  output logic       HALTED
);

  state_e state_q;
  logic   flag_c_q;
  logic   flag_z_q;
  ctrl_t  ctrl;

  // In FETCH, INSTR carries the ROM nibble one cycle early.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (RUN) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          state_q <= two_byte(INSTR) ? ST_ADDR : ST_EXEC;
        end
        ST_ADDR: state_q <= ST_EXEC;
        ST_EXEC: begin
          if (INSTR == OP_HLT) state_q <= ST_HALT;
          else if (RUN)        state_q <= ST_FETCH;
          else                 state_q <= ST_IDLE;
          if (sets_flags(INSTR)) begin
            flag_c_q <= ALU_C;
            flag_z_q <= ALU_Z;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  up_ctrl_decode u_decode (
    .state_i  (state_q),
    .instr_i  (INSTR),
    .flag_c_i (flag_c_q),
    .flag_z_i (flag_z_q),
    .ctrl_o   (ctrl)
  );

  assign PC_EN    = ctrl.pc_en;
  assign PC_LD    = ctrl.pc_ld;
  assign FETCH_EN = ctrl.fetch_en;
  assign ADDR_LD  = ctrl.addr_ld;
  assign ACC_EN   = ctrl.acc_en;
  assign ALU_SEL  = ctrl.alu_sel;
  assign OPRND_OE = ctrl.oprnd_oe;
  assign IN_OE    = ctrl.in_oe;
  assign ACC_OE   = ctrl.acc_oe;
  assign RAM_CS   = ctrl.ram_cs;
  assign RAM_WE   = ctrl.ram_we;
  assign OUT_EN   = ctrl.out_en;
  assign HALTED   = ctrl.halted;
  assign FLAG_C   = flag_c_q;
  assign FLAG_Z   = flag_z_q;

endmodule
